// File: rtl/writeback_multi_pkg.sv
// rtl/writeback_multi_pkg.sv - shared packet layouts, sizes and age helper for the writeback stage
//
// Purpose: packet field widths, packed layouts and the active-list age comparison
// shared by the writeback lanes, the writeback top and its bench.
// Layouts (MSB first):
//   wbPkt     : {seqNo, valid, alID, flags, phyDest, destData}
//   ctrlPkt   : {seqNo, valid, alID, flags, nextPC, actualDir}
//   bypassPkt : {tag, data, valid}
//   ldVioPkt  : {valid, lsqID, pc}
// wbPkt and ctrlPkt carry an alID whose width is a design parameter, so their sizes
// are functions of that width; the remaining packets have fixed layouts.
package writeback_multi_pkg;

  localparam int SEQ_NO_BITS         = 8;
  localparam int FLAG_BITS           = 8;
  localparam int PHY_REG_BITS        = 7;
  localparam int DATA_BITS           = 32;
  localparam int PC_BITS             = 32;
  localparam int LSQ_ID_BITS         = 5;
  localparam int AL_ID_BITS_DEFAULT  = 7;

  typedef struct packed {
    logic [PHY_REG_BITS-1:0] tag;
    logic [DATA_BITS-1:0]    data;
    logic                    valid;
  } bypass_pkt_t;

  typedef struct packed {
    logic                   valid;
    logic [LSQ_ID_BITS-1:0] lsqID;
    logic [PC_BITS-1:0]     pc;
  } ld_vio_pkt_t;

  localparam int BYPASS_PKT_SIZE = $bits(bypass_pkt_t);
  localparam int LD_VIO_PKT_SIZE = $bits(ld_vio_pkt_t);

  // Fixed-position wbPkt fields below the alID
  localparam int WB_DATA_LSB  = 0;
  localparam int WB_PHY_LSB   = WB_DATA_LSB + DATA_BITS;
  localparam int WB_FLAGS_LSB = WB_PHY_LSB + PHY_REG_BITS;
  localparam int WB_ALID_LSB  = WB_FLAGS_LSB + FLAG_BITS;

  function automatic int wb_pkt_size(input int al_bits);
    return SEQ_NO_BITS + 1 + al_bits + FLAG_BITS + PHY_REG_BITS + DATA_BITS;
  endfunction

  function automatic int ctrl_pkt_size(input int al_bits);
    return SEQ_NO_BITS + 1 + al_bits + FLAG_BITS + PC_BITS + 1;
  endfunction

  localparam int WB_PKT_SIZE   = wb_pkt_size(AL_ID_BITS_DEFAULT);
  localparam int CTRL_PKT_SIZE = ctrl_pkt_size(AL_ID_BITS_DEFAULT);

  // True when alID is strictly younger than recoverAlID, both measured as distance
  // from the active-list head modulo 2^width (so wrap-around is absorbed).
  function automatic logic alAgeYounger(input logic [31:0] alID,
                                        input logic [31:0] recoverAlID,
                                        input logic [31:0] headID,
                                        input int          width);
    logic [31:0] mask;
    logic [31:0] age_e;
    logic [31:0] age_r;
    mask  = (32'h1 << width) - 32'h1;
    age_e = (alID - headID) & mask;
    age_r = (recoverAlID - headID) & mask;
    return age_e > age_r;
  endfunction

endpackage

// File: rtl/writeback_lane.sv
// rtl/writeback_lane.sv - one writeback lane: DEPTH-stage pipeline with flush and valid count
//
// Purpose: carries one lane's wbPkt/ldVioPkt through DEPTH registers, squashing on
// recovery, and drives the bypass/ctrl/ldVio packets from the last stage.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   recoverFlag_i         recovery request
//   recoverAlID_i         active-list ID of the recovering instruction
//   alHeadID_i            active-list head (age origin)
//   wbPacket_i            incoming writeback packet
//   ldVioPacket_i         incoming load-violation packet
//   ctrlPacket_o          active-list update from the last stage
//   bypassPacket_o        bypass {tag, data, valid} from the last stage
//   ldVioPacket_o         load-violation packet from the last stage
//   count_o               number of valid wbPkt entries held in this lane
module writeback_lane
  import writeback_multi_pkg::*;
#(
  parameter int DEPTH           = 1,
  parameter int AL_ID_BITS      = 7,
  parameter int SELECTIVE_FLUSH = 1,
  parameter int BYPASS_FLAG_BIT = 4,
  parameter int ZERO_INVALID    = 1,
  localparam int WB             = wb_pkt_size(AL_ID_BITS),
  localparam int CT             = ctrl_pkt_size(AL_ID_BITS),
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       recoverFlag_i,
  input  logic [AL_ID_BITS-1:0]      recoverAlID_i,
  input  logic [AL_ID_BITS-1:0]      alHeadID_i,
  input  logic [WB-1:0]              wbPacket_i,
  input  logic [LD_VIO_PKT_SIZE-1:0] ldVioPacket_i,
  output logic [CT-1:0]              ctrlPacket_o,
  output logic [BYPASS_PKT_SIZE-1:0] bypassPacket_o,
  output logic [LD_VIO_PKT_SIZE-1:0] ldVioPacket_o,
  output logic [CW-1:0]              count_o
);

  localparam int VALID_POS = WB_ALID_LSB + AL_ID_BITS;
  localparam int SEQ_LSB   = VALID_POS + 1;

  logic [WB-1:0]              wb_in;
  logic [WB-1:0]              wb_src [DEPTH];
  logic [WB-1:0]              wb_d   [DEPTH];
  logic [WB-1:0]              wb_q   [DEPTH];
  logic [LD_VIO_PKT_SIZE-1:0] ld_src [DEPTH];
  logic [LD_VIO_PKT_SIZE-1:0] ld_d   [DEPTH];
  logic [LD_VIO_PKT_SIZE-1:0] ld_q   [DEPTH];
  logic [DEPTH-1:0]           squash;
  logic [CW-1:0]              cnt_d;
  logic [CW-1:0]              cnt_q;
  logic [WB-1:0]              last;
  bypass_pkt_t                bp;

  // An invalid input is blanked so stale tag/data never reach the bypass network
  assign wb_in = (ZERO_INVALID != 0 && !wbPacket_i[VALID_POS]) ? '0 : wbPacket_i;

  // Stage s loads from the input (s == 0) or from stage s-1
  always_comb begin
    wb_src[0] = wb_in;
    ld_src[0] = ldVioPacket_i;
    for (int s = 1; s < DEPTH; s++) begin
      wb_src[s] = wb_q[s-1];
      ld_src[s] = ld_q[s-1];
    end
  end

  always_comb begin
    cnt_d  = '0;
    squash = '0;
    for (int s = 0; s < DEPTH; s++) begin
      // Only valid entries are aged; an invalid wbPkt keeps its ldVio partner
      // under selective recovery.
      squash[s] = wb_src[s][VALID_POS] &&
                  alAgeYounger(32'(wb_src[s][WB_ALID_LSB +: AL_ID_BITS]),
                               32'(recoverAlID_i), 32'(alHeadID_i), AL_ID_BITS);
      wb_d[s] = wb_src[s];
      ld_d[s] = ld_src[s];
      if (recoverFlag_i) begin
        if (SELECTIVE_FLUSH == 0) begin
          wb_d[s] = '0;
          ld_d[s] = '0;
        end else if (squash[s]) begin
          wb_d[s] = '0;
          ld_d[s] = '0;
        end
      end
      cnt_d = cnt_d + CW'(wb_d[s][VALID_POS]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        wb_q[s] <= '0;
        ld_q[s] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        wb_q[s] <= wb_d[s];
        ld_q[s] <= ld_d[s];
      end
      cnt_q <= cnt_d;
    end
  end

  assign last = wb_q[DEPTH-1];

  always_comb begin
    bp       = '0;
    bp.tag   = last[WB_PHY_LSB +: PHY_REG_BITS];
    bp.data  = last[WB_DATA_LSB +: DATA_BITS];
    bp.valid = last[VALID_POS] & last[WB_FLAGS_LSB + BYPASS_FLAG_BIT];
  end

  assign bypassPacket_o = bp;
  assign ctrlPacket_o   = {last[SEQ_LSB +: SEQ_NO_BITS], last[VALID_POS],
                           last[WB_ALID_LSB +: AL_ID_BITS],
                           last[WB_FLAGS_LSB +: FLAG_BITS],
                           {PC_BITS{1'b0}}, 1'b0};
  assign ldVioPacket_o  = ld_q[DEPTH-1];
  assign count_o        = cnt_q;

endmodule

// File: rtl/writeback_multi.sv
// rtl/writeback_multi.sv - multi-lane writeback stage with selective recovery
//
// Purpose: LANES independent writeback lanes, each DEPTH stages deep, plus a live
// count of valid in-flight writeback packets.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   recoverFlag_i         recovery request (full flush or age-selective squash)
//   recoverAlID_i         active-list ID of the recovering instruction
//   alHeadID_i            active-list head (age origin)
//   wbPacket_i            LANES x wbPkt, lane i at [i*WB +: WB]
//   ldVioPacket_i         LANES x ldVioPkt
//   ctrlPacket_o          LANES x ctrlPkt to the active list
//   bypassPacket_o        LANES x bypassPkt {tag, data, valid}
//   ldVioPacket_o         LANES x ldVioPkt
//   inflight_o            number of valid wbPkt entries held across all lanes
module writeback_multi
  import writeback_multi_pkg::*;
#(
  parameter int LANES           = 2,
  parameter int DEPTH           = 1,
  parameter int AL_ID_BITS      = 7,
  parameter int SELECTIVE_FLUSH = 1,
  parameter int BYPASS_FLAG_BIT = 4,
  parameter int ZERO_INVALID    = 1,
  localparam int WB             = wb_pkt_size(AL_ID_BITS),
  localparam int CT             = ctrl_pkt_size(AL_ID_BITS),
  localparam int IW             = $clog2(LANES * DEPTH + 1),
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             recoverFlag_i,
  input  logic [AL_ID_BITS-1:0]            recoverAlID_i,
  input  logic [AL_ID_BITS-1:0]            alHeadID_i,
  input  logic [LANES*WB-1:0]              wbPacket_i,
  input  logic [LANES*LD_VIO_PKT_SIZE-1:0] ldVioPacket_i,
  output logic [LANES*CT-1:0]              ctrlPacket_o,
  output logic [LANES*BYPASS_PKT_SIZE-1:0] bypassPacket_o,
  output logic [LANES*LD_VIO_PKT_SIZE-1:0] ldVioPacket_o,
  output logic [IW-1:0]                    inflight_o
);

  logic [CW-1:0] lane_cnt [LANES];
  logic [IW-1:0] inflight_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    writeback_lane #(
      .DEPTH           (DEPTH),
      .AL_ID_BITS      (AL_ID_BITS),
      .SELECTIVE_FLUSH (SELECTIVE_FLUSH),
      .BYPASS_FLAG_BIT (BYPASS_FLAG_BIT),
      .ZERO_INVALID    (ZERO_INVALID)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .recoverFlag_i  (recoverFlag_i),
      .recoverAlID_i  (recoverAlID_i),
      .alHeadID_i     (alHeadID_i),
      .wbPacket_i     (wbPacket_i[i*WB +: WB]),
      .ldVioPacket_i  (ldVioPacket_i[i*LD_VIO_PKT_SIZE +: LD_VIO_PKT_SIZE]),
      .ctrlPacket_o   (ctrlPacket_o[i*CT +: CT]),
      .bypassPacket_o (bypassPacket_o[i*BYPASS_PKT_SIZE +: BYPASS_PKT_SIZE]),
      .ldVioPacket_o  (ldVioPacket_o[i*LD_VIO_PKT_SIZE +: LD_VIO_PKT_SIZE]),
      .count_o        (lane_cnt[i])
    );
  end

  // Lane counts are registered, so this sum changes only on clock or reset
  always_comb begin
    inflight_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      inflight_sum = inflight_sum + IW'(lane_cnt[i]);
    end
  end

  assign inflight_o = inflight_sum;

endmodule
